// File: rtl/iob_fp_fpu_issue_pkg.sv
// Shared FPU definitions: function-code width, FPU function codes and the
// issue FSM state encoding. The FPU imports the same package, so both sides
// agree on the codes.
package iob_fp_fpu_issue_pkg;

  localparam int unsigned FPU_FUNCT_W = 4;

  typedef enum logic [FPU_FUNCT_W-1:0] {
    FPU_ADD      = 4'd0,
    FPU_SUB      = 4'd1,
    FPU_MUL      = 4'd2,
    FPU_DIV      = 4'd3,
    FPU_MADD     = 4'd4,
    FPU_MSUB     = 4'd5,
    FPU_NMADD    = 4'd6,
    FPU_NMSUB    = 4'd7,
    FPU_SQRT     = 4'd8,
    FPU_MIN      = 4'd9,
    FPU_MAX      = 4'd10,
    FPU_CVT_W_S  = 4'd11,
    FPU_CVT_WU_S = 4'd12,
    FPU_CVT_S_W  = 4'd13,
    FPU_CVT_S_WU = 4'd14,
    FPU_CVT_X_W  = 4'd15
  } fpu_funct_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_WAIT  = 2'd2
  } issue_state_e;

endpackage

// File: rtl/iob_fp_fpu_issue_if.sv
// Bundle of the request, FPU and response signals of the FPU issue block.
//   slave  : the issue block's view (takes requests, drives the FPU, returns responses)
//   master : the environment's view (sends requests, plays the FPU, takes responses)
interface iob_fp_fpu_issue_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned FUNCT_W = 4,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned LAT_W   = 16
);
  logic               req_valid_i;
  logic               req_ready_o;
  logic [FUNCT_W-1:0] req_funct_i;
  logic [DATA_W-1:0]  req_rs1_i;
  logic [DATA_W-1:0]  req_rs2_i;
  logic [DATA_W-1:0]  req_rs3_i;
  logic [DATA_W-1:0]  req_rs1_int_i;
  logic [TAG_W-1:0]   req_tag_i;

  logic               fpu_start_o;
  logic [FUNCT_W-1:0] fpu_funct_o;
  logic [DATA_W-1:0]  fpu_rs1_o;
  logic [DATA_W-1:0]  fpu_rs2_o;
  logic [DATA_W-1:0]  fpu_rs3_o;
  logic [DATA_W-1:0]  fpu_rs1_int_o;
  logic [DATA_W-1:0]  fpu_res_i;
  logic               fpu_done_i;

  logic               rsp_valid_o;
  logic               rsp_ready_i;
  logic [DATA_W-1:0]  rsp_res_o;
  logic [TAG_W-1:0]   rsp_tag_o;
  logic [LAT_W-1:0]   rsp_lat_o;
  logic               busy_o;

  modport slave (
    input  req_valid_i, req_funct_i, req_rs1_i, req_rs2_i, req_rs3_i,
           req_rs1_int_i, req_tag_i, fpu_res_i, fpu_done_i, rsp_ready_i,
    output req_ready_o, fpu_start_o, fpu_funct_o, fpu_rs1_o, fpu_rs2_o,
           fpu_rs3_o, fpu_rs1_int_o, rsp_valid_o, rsp_res_o, rsp_tag_o,
           rsp_lat_o, busy_o
  );

  modport master (
    output req_valid_i, req_funct_i, req_rs1_i, req_rs2_i, req_rs3_i,
           req_rs1_int_i, req_tag_i, fpu_res_i, fpu_done_i, rsp_ready_i,
    input  req_ready_o, fpu_start_o, fpu_funct_o, fpu_rs1_o, fpu_rs2_o,
           fpu_rs3_o, fpu_rs1_int_o, rsp_valid_o, rsp_res_o, rsp_tag_o,
           rsp_lat_o, busy_o
  );
endinterface

// File: rtl/iob_fp_fpu_issue_fifo.sv
// Two-entry request FIFO.
//   i_clk, i_rst_n : clock, synchronous active-low reset (empties the FIFO)
//   i_push, i_data : write an entry; accepted when not full or when popping
//   i_pop          : drop the head entry (ignored when empty)
//   o_data         : head entry
//   o_full/o_empty : occupancy flags
module iob_fp_fpu_issue_fifo #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  logic [W-1:0] r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_count;
  logic         w_do_push;
  logic         w_do_pop;

  assign o_full    = (r_count == 2'd2);
  assign o_empty   = (r_count == 2'd0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rptr];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= ~r_wptr;
      if (w_do_pop)  r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end
  end

  // Storage needs no reset: it is only read through the occupancy count.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end
endmodule

// File: rtl/iob_fp_fpu_issue.sv
// FPU issue block: queues requests, issues one at a time to the FPU and holds
// the result until the consumer takes it.
//   clk_i   : clock
//   rst_n_i : synchronous active-low reset, abandons any operation in flight
//   bus     : req_* request handshake, fpu_* FPU start/done, rsp_* response
//             handshake with result, tag and saturating latency, busy_o
module iob_fp_fpu_issue
  import iob_fp_fpu_issue_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned FUNCT_W = FPU_FUNCT_W,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned LAT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  iob_fp_fpu_issue_if.slave  bus
);
  localparam int unsigned ENTRY_W = FUNCT_W + 4*DATA_W + TAG_W;

  logic [ENTRY_W-1:0] w_push_data;
  logic [ENTRY_W-1:0] w_head;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_capture;
  logic [LAT_W-1:0]   w_lat_inc;

  issue_state_e       r_state;
  issue_state_e       w_state_nxt;

  logic [FUNCT_W-1:0] r_funct;
  logic [DATA_W-1:0]  r_rs1;
  logic [DATA_W-1:0]  r_rs2;
  logic [DATA_W-1:0]  r_rs3;
  logic [DATA_W-1:0]  r_rs1_int;
  logic [TAG_W-1:0]   r_tag;
  logic [LAT_W-1:0]   r_lat;
  logic               r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_res;
  logic [TAG_W-1:0]   r_rsp_tag;
  logic [LAT_W-1:0]   r_rsp_lat;

  assign w_push      = bus.req_valid_i && !w_full;
  assign w_push_data = {bus.req_funct_i, bus.req_rs1_i, bus.req_rs2_i,
                        bus.req_rs3_i, bus.req_rs1_int_i, bus.req_tag_i};

  iob_fp_fpu_issue_fifo #(.W(ENTRY_W)) u_fifo (
    .i_clk   (clk_i),
    .i_rst_n (rst_n_i),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_lat_inc = (r_lat == '1) ? r_lat : r_lat + 1'b1;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Issue waits for a free response slot; since the slot frees on the
  // consumption edge, issue is at the earliest one edge later. FIRST always
  // lasts one cycle so a done left over from the previous operation is ignored.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_empty && !r_rsp_valid) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_FIRST;
        end
      end
      ST_FIRST: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (bus.fpu_done_i) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_funct     <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rs3       <= '0;
      r_rs1_int   <= '0;
      r_tag       <= '0;
      r_lat       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_res   <= '0;
      r_rsp_tag   <= '0;
      r_rsp_lat   <= '0;
    end else begin
      if (w_pop) begin
        {r_funct, r_rs1, r_rs2, r_rs3, r_rs1_int, r_tag} <= w_head;
        r_lat <= '0;
      end else if (r_state != ST_IDLE) begin
        r_lat <= w_lat_inc;
      end
      // Capture and consumption never coincide: issue requires an empty slot.
      if (w_capture) begin
        r_rsp_valid <= 1'b1;
        r_rsp_res   <= bus.fpu_res_i;
        r_rsp_tag   <= r_tag;
        r_rsp_lat   <= w_lat_inc;
      end else if (r_rsp_valid && bus.rsp_ready_i) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign bus.req_ready_o   = !w_full;
  assign bus.fpu_start_o   = (r_state != ST_IDLE);
  assign bus.busy_o        = (r_state != ST_IDLE);
  assign bus.fpu_funct_o   = r_funct;
  assign bus.fpu_rs1_o     = r_rs1;
  assign bus.fpu_rs2_o     = r_rs2;
  assign bus.fpu_rs3_o     = r_rs3;
  assign bus.fpu_rs1_int_o = r_rs1_int;
  assign bus.rsp_valid_o   = r_rsp_valid;
  assign bus.rsp_res_o     = r_rsp_res;
  assign bus.rsp_tag_o     = r_rsp_tag;
  assign bus.rsp_lat_o     = r_rsp_lat;
endmodule
